inst_queue_param: RTL
=====================

# inst_queue_param

Parametrised multi-lane instruction queue between fetch and the issue decoder. Each cycle it accepts up to WR_LANES contiguous fetched entries and presents the oldest RD_LANES entries to issue. Issue retires 0..RD_LANES of them per cycle, and a flush clears the whole queue. It generalises the fixed 4-in/2-out queue to any lane count and depth, and adds the following:

- back-pressure;
- pop clamping;
- an overflow flag;
- optional same-cycle write-to-read bypass.

## Interface

Parameters:
- ENTRY_W, 104: payload bits per entry (PC, inst, prediction, exception fields, packed by the caller).
- DEPTH, 16: number of entries. Must be a power of two and must be ≥ WR_LANES+RD_LANES+GAP.
- WR_LANES, 4: maximum entries pushed per cycle.
- RD_LANES, 2: entries presented, and maximum popped, per cycle.
- GAP, 4: slack reserved for fetches already in flight, used by stop_fetch_o.

Ports. PW = $clog2(DEPTH)+1; NW = $clog2(WR_LANES+1); NR = $clog2(RD_LANES+1).
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous clear (branch mispredict or exception).
- wr_valid_i  in  1  push request.
- wr_num_i  in  NW  entries pushed from lanes 0..wr_num_i-1. Values above WR_LANES are treated as WR_LANES.
- wr_data_i  in  WR_LANES*ENTRY_W  lane i occupies bits [i*ENTRY_W +: ENTRY_W].
- wr_ready_o  out  1  free ≥ WR_LANES.
- rd_pop_i  in  NR  entries the issue stage consumes this cycle.
- rd_valid_o  out  RD_LANES  thermometer; bit i set when output lane i holds a valid entry.
- rd_data_o  out  RD_LANES*ENTRY_W  lane i is the i-th oldest entry.
- count_o  out  PW  current occupancy.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == DEPTH.
- stop_fetch_o  out  1  free < WR_LANES+GAP.
- ovf_o  out  1  one-cycle pulse when a push is rejected.

## Operation

- Storage is a register array of DEPTH entries with PW-bit head and tail pointers. The MSB is the wrap bit. The array index is ptr[PW-2:0].
- count = tail - head, computed modulo 2^PW. free = DEPTH - count.
- Push acceptance:
  - accept = wr_valid_i && wr_ready_o && !flush_i.
  - On accept, lane i < wr_num_i is written to index tail+i, wrapping modulo DEPTH.
  - tail advances by wr_num_i. An accepted push with wr_num_i = 0 is a no-op.
- Rejected push: wr_valid_i && !wr_ready_o && !flush_i writes nothing, leaves tail unchanged and pulses ovf_o on the next cycle.
- Read side:
  - rd_data_o lane i = entry[head+i], combinational from the array.
  - rd_valid_o[i] = (count > i).
  - Lanes at or above count present don't-care data with valid low.
- Pop: pop_eff = min(rd_pop_i, avail), where avail is the number of set bits in rd_valid_o. head advances by pop_eff. Over-popping never corrupts state.
- Simultaneous push and pop in one cycle are legal. wr_ready_o uses the pre-pop count, so it is conservative.
- Flush: flush_i takes priority over push and pop. On the next cycle head = tail = 0. Any push in the flush cycle is discarded and does not pulse ovf_o.
- Reset (rst high, asynchronous) sets the following immediately, regardless of clk:
  - head = tail = 0;
  - count_o = 0, empty_o = 1, full_o = 0;
  - wr_ready_o = 1, stop_fetch_o = 0;
  - rd_valid_o = 0, ovf_o = 0.
- Array contents are not reset.

## Timing

- Push-to-visible latency is 1 cycle: an entry accepted in cycle N appears on rd_data_o/rd_valid_o in cycle N+1 (0 cycles with bypass, see Configuration).
- Pop takes effect on the next edge. The next oldest entry is presented in cycle N+1.
- count_o, empty_o, full_o, wr_ready_o and stop_fetch_o are all derived from the registered pointers, so they are glitch-free with respect to the current cycle's inputs.
- Pointer wrap is seamless: a push straddling index DEPTH-1→0 writes both ends in the same cycle.
- Reset asserted mid-operation clears state within the same cycle. The first push is accepted on the first edge after rst deasserts.

## Configuration

IQ_BYPASS_EN:
- Defined: when count < RD_LANES, output lanes count..RD_LANES-1 are filled combinationally from wr_data_i lanes 0.., but only when accept is true this cycle.
  - rd_valid_o[i] = (i < count + wr_num_i).
  - The pop limit becomes min(rd_pop_i, count + accepted wr_num_i, RD_LANES).
  - Bypassed entries are still written to the array; head simply passes them.
- Undefined: no write-to-read path, and push-to-visible latency is 1 cycle.

## Test plan

- Reset, then push 4 entries (data 0x10..0x13), pop 0 → next cycle count_o=4, rd_valid_o=2'b11, rd_data lanes = 0x10, 0x11.
- With DEPTH=16, fill to count 12 → wr_ready_o=1 and stop_fetch_o=1. At count 13 → wr_ready_o=0, and a further push leaves count at 13 and pulses ovf_o.
- head=tail=14, push 4 → entries land at indices 14, 15, 0, 1. Pop 2 twice → all 4 read back in order.
- count=1 with rd_pop_i=2 → pop_eff=1, count_o=0, empty_o=1.
- Flush with simultaneous push of 3 and pop of 2 → next cycle count_o=0, ovf_o=0.
- IQ_BYPASS_EN defined, empty queue, push 0xA0,0xA1 with rd_pop_i=2 → same-cycle rd_valid_o=2'b11 with data 0xA0,0xA1; next cycle count_o=0.

Source files
------------

// File: rtl/inst_queue_param_if.sv
// Fetch/issue-facing signal bundle for inst_queue_param.
// Valid/ready: an entry group moves only in a cycle where wr_valid_i && wr_ready_o (and no flush).
interface inst_queue_param_if #(
  parameter int ENTRY_W  = 104,
  parameter int DEPTH    = 16,
  parameter int WR_LANES = 4,
  parameter int RD_LANES = 2
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int NW = $clog2(WR_LANES + 1);
  localparam int NR = $clog2(RD_LANES + 1);

  logic                         flush_i;
  logic                         wr_valid_i;
  logic [NW-1:0]                wr_num_i;
  logic [WR_LANES*ENTRY_W-1:0]  wr_data_i;
  logic                         wr_ready_o;
  logic [NR-1:0]                rd_pop_i;
  logic [RD_LANES-1:0]          rd_valid_o;
  logic [RD_LANES*ENTRY_W-1:0]  rd_data_o;
  logic [PW-1:0]                count_o;
  logic                         empty_o;
  logic                         full_o;
  logic                         stop_fetch_o;
  logic                         ovf_o;

  // master = fetch/issue side, slave = the queue
  modport master (
    output flush_i, wr_valid_i, wr_num_i, wr_data_i, rd_pop_i,
    input  wr_ready_o, rd_valid_o, rd_data_o, count_o, empty_o, full_o,
           stop_fetch_o, ovf_o
  );
  modport slave (
    input  flush_i, wr_valid_i, wr_num_i, wr_data_i, rd_pop_i,
    output wr_ready_o, rd_valid_o, rd_data_o, count_o, empty_o, full_o,
           stop_fetch_o, ovf_o
  );
endinterface

// File: rtl/inst_queue_param.sv
// Multi-lane instruction queue: up to WR_LANES pushes and RD_LANES pops per cycle.
// Define IQ_BYPASS_EN for a same-cycle write-to-read path into empty output lanes.
module inst_queue_param #(
  parameter int ENTRY_W  = 104,
  parameter int DEPTH    = 16,
  parameter int WR_LANES = 4,
  parameter int RD_LANES = 2,
  parameter int GAP      = 4
) (
  input  logic               clk,
  input  logic               rst,
  inst_queue_param_if.slave  q
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;
  localparam int NW = $clog2(WR_LANES + 1);
  localparam int NR = $clog2(RD_LANES + 1);

  typedef logic [PW-1:0] ptr_t;

  ptr_t                 head_q, head_d;
  ptr_t                 tail_q, tail_d;
  logic                 ovf_q, ovf_d;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [ENTRY_W-1:0]   mem_d [DEPTH];

  ptr_t                 count;
  ptr_t                 free;
  logic                 wr_ready;
  logic [NW-1:0]        wr_num_c;
  logic                 accept;
  logic [PW:0]          visible;
  logic [NR-1:0]        avail;
  logic [NR-1:0]        pop_c;
  logic [NR-1:0]        pop_eff;
  logic [RD_LANES-1:0]  rd_valid;
  logic [RD_LANES*ENTRY_W-1:0] rd_data;

  always_comb begin
    count    = tail_q - head_q;
    free     = ptr_t'(DEPTH) - count;
    wr_ready = (free >= ptr_t'(WR_LANES));
    wr_num_c = (q.wr_num_i > NW'(WR_LANES)) ? NW'(WR_LANES) : q.wr_num_i;
    accept   = q.wr_valid_i && wr_ready && !q.flush_i;

    // Entries the read side can see this cycle (array plus any bypassed lanes)
    visible = {1'b0, count};
`ifdef IQ_BYPASS_EN
    if (accept) visible = {1'b0, count} + (PW+1)'(wr_num_c);
`endif
    avail   = (visible >= (PW+1)'(RD_LANES)) ? NR'(RD_LANES) : NR'(visible);
    pop_c   = (q.rd_pop_i > NR'(RD_LANES)) ? NR'(RD_LANES) : q.rd_pop_i;
    pop_eff = (pop_c > avail) ? avail : pop_c;

    rd_valid = '0;
    rd_data  = '0;
    for (int i = 0; i < RD_LANES; i++) begin
      rd_valid[i] = (visible > (PW+1)'(i));
      rd_data[i*ENTRY_W +: ENTRY_W] = mem_q[AW'(head_q + ptr_t'(i))];
`ifdef IQ_BYPASS_EN
      for (int j = 0; j < WR_LANES; j++) begin
        if (accept && (NW'(j) < wr_num_c) && (ptr_t'(i) == count + ptr_t'(j)))
          rd_data[i*ENTRY_W +: ENTRY_W] = q.wr_data_i[j*ENTRY_W +: ENTRY_W];
      end
`endif
    end
  end

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q + ptr_t'(pop_eff);
    tail_d = tail_q;
    ovf_d  = q.wr_valid_i && !wr_ready && !q.flush_i;
    if (accept) begin
      tail_d = tail_q + ptr_t'(wr_num_c);
      for (int i = 0; i < WR_LANES; i++) begin
        if (NW'(i) < wr_num_c)
          mem_d[AW'(tail_q + ptr_t'(i))] = q.wr_data_i[i*ENTRY_W +: ENTRY_W];
      end
    end
    if (q.flush_i) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ovf_q  <= ovf_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign q.count_o      = count;
  assign q.empty_o      = (count == '0);
  assign q.full_o       = (count == ptr_t'(DEPTH));
  assign q.wr_ready_o   = wr_ready;
  assign q.stop_fetch_o = (free < ptr_t'(WR_LANES + GAP));
  assign q.ovf_o        = ovf_q;
  assign q.rd_valid_o   = rd_valid;
  assign q.rd_data_o    = rd_data;
endmodule
